// File: rtl/borrow_chain_seq.sv
// Sequential borrow-ripple decrementer: oneC = twoC - (1 << LSB_POS) mod 2^WIDTH, CHUNK bits per cycle.
// Optional build macro EARLY_EXIT_EN: finish as soon as the borrow dies out instead of after all chunks.
module borrow_chain_seq #(
  parameter int WIDTH   = 19,
  parameter int CHUNK   = 4,
  parameter int LSB_POS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] twoC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] oneC,
  output logic             underflow
);

  localparam int NCH   = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   data;
  logic [WIDTH-1:0]   data_nxt;
  logic               borrow;
  logic               borrow_nxt;
  logic [IDX_W-1:0]   idx;
  logic               last_chunk;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign oneC       = data;
  assign last_chunk = (idx == IDX_W'(NCH - 1));

  // Resolve the current chunk; scanning bits in ascending order lets the borrow ripple inside it.
  always_comb begin
    logic b;
    data_nxt = data;
    b        = borrow;
    for (int i = 0; i < WIDTH; i++) begin
      if ((IDX_W'(i / CHUNK) == idx) && (i >= LSB_POS)) begin
        data_nxt[i] = data[i] ^ b;
        b           = ~data[i] & b;
      end
    end
    borrow_nxt = b;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN: begin
        if (last_chunk) state_nxt = DONE;
`ifdef EARLY_EXIT_EN
        else if (!borrow_nxt) state_nxt = DONE;
`endif
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      data      <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            data      <= twoC;
            borrow    <= 1'b1;
            idx       <= '0;
            underflow <= 1'b0;
          end
        end
        RUN: begin
          data   <= data_nxt;
          borrow <= borrow_nxt;
          idx    <= idx + IDX_W'(1);
          // An early exit leaves underflow at the 0 loaded on accept.
          if (last_chunk) underflow <= borrow_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_borrow_chain_seq.sv
// Directed bench for borrow_chain_seq: reset, fixed vectors, backpressure, mid-run reset, round trip.
module tb_borrow_chain_seq;
  localparam int W = 19;
`ifdef EARLY_EXIT_EN
  localparam int LAT_SHORT = 1;
`else
  localparam int LAT_SHORT = 5;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] twoC = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] oneC;
  logic         underflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  borrow_chain_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .twoC      (twoC),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .oneC      (oneC),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x);
    int guard = 0;
    while (!in_ready && guard < 64) begin
      tick();
      guard++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    twoC     = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("out_timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [W-1:0] x, input logic [W-1:0] exp_o,
                     input logic exp_u, input int exp_lat);
    int lat;
    send(x);
    wait_out(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_oneC"}, 32'(oneC), 32'(exp_o));
    chk({tag, "_uf"}, 32'(underflow), 32'(exp_u));
    take();
    chk({tag, "_ovld_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_irdy_after"}, 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] exp_q[$];
  int           rx_cnt;

  initial begin
    int lat;
    logic [W-1:0] held;

    repeat (2) tick();
    reset = 1'b0;
    chk("rst_irdy", 32'(in_ready), 32'd1);
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_oneC", 32'(oneC), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);

    vec("v6", 19'h00006, 19'h00004, 1'b0, LAT_SHORT);
    vec("v0", 19'h00000, 19'h7FFFE, 1'b1, 5);
    vec("v40000", 19'h40000, 19'h3FFFE, 1'b0, 5);
    vec("v3", 19'h00003, 19'h00001, 1'b0, LAT_SHORT);
    vec("v1", 19'h00001, 19'h7FFFF, 1'b1, 5);

    // Backpressure: result held in DONE while a competing word is offered.
    send(19'h40000);
    wait_out(lat);
    held     = oneC;
    in_valid = 1'b1;
    twoC     = 19'h12345;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_ovld", 32'(out_valid), 32'd1);
      chk("bp_oneC", 32'(oneC), 32'(held));
      chk("bp_irdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("bp_value", 32'(held), 32'h3FFFE);
    take();
    chk("bp_rel_ovld", 32'(out_valid), 32'd0);
    chk("bp_rel_irdy", 32'(in_ready), 32'd1);
    tick();
    chk("bp_single_ovld", 32'(out_valid), 32'd0);
    chk("bp_single_irdy", 32'(in_ready), 32'd1);

    // Reset during the third RUN cycle discards the word.
    send(19'h00000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_irdy", 32'(in_ready), 32'd1);
    chk("mr_ovld", 32'(out_valid), 32'd0);
    chk("mr_oneC", 32'(oneC), 32'd0);
    chk("mr_uf", 32'(underflow), 32'd0);
    vec("mr_v2", 19'h00002, 19'h00000, 1'b0, LAT_SHORT);

    // Round trip through the +2 chain with random consumer backpressure.
    rx_cnt = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [W-1:0] x;
          logic         acc;
          int           guard;
          x = W'($urandom);
          exp_q.push_back(x);
          in_valid = 1'b1;
          twoC     = x + W'(2);
          acc      = 1'b0;
          guard    = 0;
          while (!acc && guard < 200) begin
            acc = in_ready;
            tick();
            guard++;
          end
          in_valid = 1'b0;
          if (!acc) begin
            chk("rt_accept_timeout", 32'd0, 32'd1);
            break;
          end
        end
      end
      begin
        int cyc = 0;
        while (rx_cnt < 1000 && cyc < 40000) begin
          logic hs;
          out_ready = ($urandom_range(0, 3) != 0);
          hs = out_valid && out_ready;
          if (hs) begin
            if (exp_q.size() == 0) begin
              chk("rt_dup", 32'd1, 32'd0);
            end else begin
              chk("rt_oneC", 32'(oneC), 32'(exp_q.pop_front()));
            end
            rx_cnt++;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    chk("rt_count", 32'(rx_cnt), 32'd1000);
    chk("rt_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (8) tick();
    chk("rt_no_extra", 32'(out_valid), 32'd0);
    chk("rt_idle", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
